sensors_average: RTL and testbench
==================================

# sensors_average

Sequential averaging stage directly upstream of the temperature display/alert encoder. On a start pulse it snapshots all sensor readings and their enable mask, sums the active readings one sensor per cycle, then runs a 16-step restoring division by the active-sensor count. It presents quotient, remainder and count as registered outputs with a one-cycle valid strobe, in the form the display stage consumes (`temp_Q`, `temp_R`, `active_sensors_nr`).

## Interface
- `NR_SENSORS`, default 5: number of sensor channels, 1..16.
- `DATA_W`, default 8: width of one sensor reading, unsigned.
- `clk_i` in 1: system clock, rising edge.
- `rst_n_i` in 1: asynchronous active-low reset.
- `start_i` in 1: request one averaging run; sampled only in IDLE.
- `sensors_data_i` in NR_SENSORS*DATA_W: packed readings; sensor k occupies bits [k*DATA_W +: DATA_W].
- `sensors_en_i` in NR_SENSORS: bit k=1 means sensor k is active.
- `busy_o` out 1: high from the cycle after start is accepted until `valid_o` drops.
- `valid_o` out 1: one-cycle strobe; new result present on the outputs.
- `temp_Q_o` out 16: average quotient, floor(sum/count).
- `temp_R_o` out 16: remainder, sum mod count.
- `active_sensors_nr_o` out 8: number of sensors counted in the sum.

## Operation
- States: IDLE, ACCUM, DIVIDE, DONE.
- IDLE: if `start_i`=1, latch `sensors_data_i` and `sensors_en_i` into snapshot registers, clear the sum, count and index, then go to ACCUM. Input changes after this edge do not affect the run.
- ACCUM: one sensor per cycle, index 0..NR_SENSORS-1. If the snapshot enable bit is set, add the reading (zero-extended) to the 16-bit sum and increment the 8-bit count. After index NR_SENSORS-1, go to DIVIDE.
- DIVIDE: exactly 16 restoring-division iterations, MSB first: shift the remainder left, bring in the next sum bit, and subtract the count when remainder ≥ count. The step counter is 4 bits and wraps 15→0 on exit to DONE.
- Count = 0: the division still runs all 16 steps, but the result is forced to Q=0, R=0 and `active_sensors_nr_o`=0. No X and no division by zero.
- DONE: register Q, R and count into the outputs and assert `valid_o` for this one cycle, then return to IDLE.
- Outputs hold the last result until the next DONE. They are never cleared by a new start.
- `start_i` in any state other than IDLE is ignored. It is not queued.
- Width rule: the sum never overflows, since NR_SENSORS*(2^DATA_W-1) ≤ 16*255 < 2^16.

## Timing
- Reset (async assert, sync release): state=IDLE; `busy_o`=0, `valid_o`=0, `temp_Q_o`=0, `temp_R_o`=0, `active_sensors_nr_o`=0.
- Reset asserted mid-run aborts immediately. The partial result is discarded and all outputs return to reset values.
- Latency is fixed. With the start edge as cycle 0, `valid_o` is high during cycle NR_SENSORS+17; that is cycle 22 for the defaults.
- `busy_o` is high for cycles 1..NR_SENSORS+17.
- Earliest next start is sampled in the cycle after the `valid_o` cycle.
- Throughput: one result per NR_SENSORS+18 cycles.

## Configuration
- `SENSORS_AVG_RANGE_CHECK_EN`
  - Defined: in ACCUM, a reading greater than 8'd100 is treated as a faulted sensor. It is excluded from both the sum and the count, regardless of its enable bit.
  - Undefined: every enabled reading is accumulated unchecked.
- Latency is identical in both builds.

## Test plan
- All 5 enabled, readings 20,21,22,23,24, start → `valid_o` at cycle 22 with Q=22, R=0, count=5; `busy_o` high for cycles 1..22.
- `sensors_en_i`=5'b10101, readings 20,x,21,x,24 → Q=21, R=2, count=3.
- `sensors_en_i`=0 → Q=0, R=0, count=0, `valid_o` still at cycle 22.
- Second `start_i` pulse at cycle 10, and input data changed at cycle 3 → the single result reflects the cycle-0 snapshot; no second run starts.
- `rst_n_i` low at cycle 15 (inside DIVIDE) → all outputs 0 at once; a fresh start afterwards yields the correct result at +22 cycles.
- Macro defined, enabled readings 20,150,22,30,24 → count=4, sum=96, Q=24, R=0. Macro undefined, same readings → count=5, Q=49, R=1.

Source files
------------

// File: rtl/sensors_average.sv
// Sequential sensor averager: snapshot, accumulate one sensor per cycle, 16-step restoring divide.
// Optional build macro SENSORS_AVG_RANGE_CHECK_EN drops readings above 100 as faulted sensors.
module sensors_average #(
  parameter int NR_SENSORS = 5,
  parameter int DATA_W     = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         start_i,
  input  logic [NR_SENSORS*DATA_W-1:0] sensors_data_i,
  input  logic [NR_SENSORS-1:0]        sensors_en_i,
  output logic                         busy_o,
  output logic                         valid_o,
  output logic [15:0]                  temp_Q_o,
  output logic [15:0]                  temp_R_o,
  output logic [7:0]                   active_sensors_nr_o,
  output logic [1:0]                   dbg_state_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NR_SENSORS - 1);

  state_t state, state_next;

  logic [NR_SENSORS*DATA_W-1:0] snap_data;
  logic [NR_SENSORS-1:0]        snap_en;
  logic [15:0]                  sum;
  logic [7:0]                   cnt;
  logic [3:0]                   idx;
  logic [3:0]                   step;
  logic [15:0]                  quo;
  logic [15:0]                  rem;

  logic [DATA_W-1:0] rd;
  logic              rd_en;
  logic              take;
  logic [15:0]       acc_sum_next;
  logic [7:0]        acc_cnt_next;
  logic [16:0]       rem_sh;
  logic              ge;
  logic [15:0]       q_next;
  logic [15:0]       r_next;

  assign busy_o      = (state != IDLE);
  assign valid_o     = (state == DONE);
  assign dbg_state_o = state;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i) state_next = ACCUM;
      ACCUM:   if (idx == LAST_IDX) state_next = DIVIDE;
      DIVIDE:  if (step == 4'd15) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Snapshot mux for the sensor currently being accumulated.
  always_comb begin
    rd    = '0;
    rd_en = 1'b0;
    for (int k = 0; k < NR_SENSORS; k++) begin
      if (idx == 4'(k)) begin
        rd    = snap_data[k*DATA_W +: DATA_W];
        rd_en = snap_en[k];
      end
    end
  end

`ifdef SENSORS_AVG_RANGE_CHECK_EN
  assign take = rd_en && (16'(rd) <= 16'd100);
`else
  assign take = rd_en;
`endif

  assign acc_sum_next = take ? (sum + 16'(rd)) : sum;
  assign acc_cnt_next = take ? (cnt + 8'd1) : cnt;

  // One restoring step; a zero count subtracts nothing and the result is masked at the end.
  assign rem_sh = {rem, quo[15]};
  assign ge     = (rem_sh >= {9'b0, cnt});
  assign r_next = ge ? 16'(rem_sh - {9'b0, cnt}) : rem_sh[15:0];
  assign q_next = {quo[14:0], ge};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      snap_data           <= '0;
      snap_en             <= '0;
      sum                 <= '0;
      cnt                 <= '0;
      idx                 <= '0;
      step                <= '0;
      quo                 <= '0;
      rem                 <= '0;
      temp_Q_o            <= '0;
      temp_R_o            <= '0;
      active_sensors_nr_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            snap_data <= sensors_data_i;
            snap_en   <= sensors_en_i;
            sum       <= '0;
            cnt       <= '0;
            idx       <= '0;
          end
        end
        ACCUM: begin
          sum  <= acc_sum_next;
          cnt  <= acc_cnt_next;
          idx  <= idx + 4'd1;
          quo  <= acc_sum_next;
          rem  <= '0;
          step <= '0;
        end
        DIVIDE: begin
          quo  <= q_next;
          rem  <= r_next;
          step <= step + 4'd1;
          // Results land on the edge into DONE so they are visible with valid_o.
          if (step == 4'd15) begin
            temp_Q_o            <= (cnt == 8'd0) ? 16'd0 : q_next;
            temp_R_o            <= (cnt == 8'd0) ? 16'd0 : r_next;
            active_sensors_nr_o <= cnt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sensors_average.sv
// Self-checking bench for sensors_average: vector table plus scoreboard, with
// hand-written sequences for ignored restart, input changes mid-run and mid-run reset.
module tb_sensors_average;

  localparam int NR  = 5;
  localparam int DW  = 8;
  localparam int LAT = NR + 17;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [NR*DW-1:0] data;
  logic [NR-1:0]   en;
  logic            busy;
  logic            valid;
  logic [15:0]     temp_q;
  logic [15:0]     temp_r;
  logic [7:0]      nr;
  logic [1:0]      dbg_state;

  int errors = 0;
  int checks = 0;

  logic [39:0] exp_q[$];
  logic [39:0] last_out;

  typedef struct packed {
    logic [39:0] d;
    logic [4:0]  e;
    logic [15:0] q;
    logic [15:0] r;
    logic [7:0]  c;
  } vec_t;

  vec_t tbl[7];

  sensors_average #(.NR_SENSORS(NR), .DATA_W(DW)) dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .start_i             (start),
    .sensors_data_i      (data),
    .sensors_en_i        (en),
    .busy_o              (busy),
    .valid_o             (valid),
    .temp_Q_o            (temp_q),
    .temp_R_o            (temp_r),
    .active_sensors_nr_o (nr),
    .dbg_state_o         (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] pack5(input logic [7:0] a0, input logic [7:0] a1,
                                        input logic [7:0] a2, input logic [7:0] a3,
                                        input logic [7:0] a4);
    return {a4, a3, a2, a1, a0};
  endfunction

  // Reference average computed with plain integer arithmetic.
  function automatic logic [39:0] model(input logic [39:0] d, input logic [4:0] e);
    int s;
    int c;
    logic [7:0] v;
    s = 0;
    c = 0;
    for (int k = 0; k < NR; k++) begin
      v = d[k*8 +: 8];
`ifdef SENSORS_AVG_RANGE_CHECK_EN
      if (e[k] && v <= 8'd100) begin s += int'(v); c++; end
`else
      if (e[k]) begin s += int'(v); c++; end
`endif
    end
    if (c == 0) return 40'd0;
    return {16'(s / c), 16'(s % c), 8'(c)};
  endfunction

  // Scoreboard: every valid strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {temp_q, temp_r, nr}, 40'hx_dead_dead);
      end else begin
        chk("result_qrc", {temp_q, temp_r, nr}, exp_q.pop_front());
      end
    end
  end

  task automatic run(input logic [39:0] d, input logic [4:0] e, input logic [39:0] exp,
                     input bit disturb);
    int  valid_cyc;
    bit  busy_ok;
    logic [39:0] prev;
    prev = last_out;
    @(negedge clk);
    data  = d;
    en    = e;
    start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    valid_cyc = -1;
    busy_ok   = 1'b1;
    for (int cyc = 1; cyc <= LAT + 1; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (disturb && cyc == 3) begin data = ~d; en = ~e; end
      if (disturb && cyc == 10) start = 1'b1;
      if (disturb && cyc == 11) start = 1'b0;
      if (cyc == 5) chk("outputs_hold", {temp_q, temp_r, nr}, prev);
      if (busy !== (cyc <= LAT)) busy_ok = 1'b0;
      if (valid === 1'b1 && valid_cyc < 0) valid_cyc = cyc;
    end
    chk("valid_latency", 64'(valid_cyc), 64'(LAT));
    chk("busy_window", 64'(busy_ok), 64'd1);
    last_out = exp;
  endtask

  initial begin
    logic [39:0] rd;
    logic [4:0]  re;
    bit          stray;

    rst_n    = 1'b0;
    start    = 1'b0;
    data     = '0;
    en       = '0;
    last_out = '0;

    tbl[0] = '{d: pack5(20, 21, 22, 23, 24), e: 5'b11111, q: 22, r: 0, c: 5};
    tbl[1] = '{d: pack5(20, 99, 21, 77, 24), e: 5'b10101, q: 21, r: 2, c: 3};
    tbl[2] = '{d: pack5(200, 3, 9, 1, 50),   e: 5'b00000, q: 0,  r: 0, c: 0};
`ifdef SENSORS_AVG_RANGE_CHECK_EN
    tbl[3] = '{d: pack5(20, 150, 22, 30, 24), e: 5'b11111, q: 24, r: 0, c: 4};
    tbl[4] = '{d: pack5(255, 255, 255, 255, 255), e: 5'b11111, q: 0, r: 0, c: 0};
`else
    tbl[3] = '{d: pack5(20, 150, 22, 30, 24), e: 5'b11111, q: 49, r: 1, c: 5};
    tbl[4] = '{d: pack5(255, 255, 255, 255, 255), e: 5'b11111, q: 255, r: 0, c: 5};
`endif
    tbl[5] = '{d: pack5(9, 9, 9, 9, 7),      e: 5'b10000, q: 7,  r: 0, c: 1};
    tbl[6] = '{d: pack5(0, 1, 2, 3, 4),      e: 5'b01111, q: 1,  r: 2, c: 4};

    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_valid", 64'(valid), 64'd0);
    chk("reset_outputs", {temp_q, temp_r, nr}, 40'd0);
    chk("reset_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run(tbl[i].d, tbl[i].e, {tbl[i].q, tbl[i].r, tbl[i].c}, 1'b0);
    end

    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < NR; k++) rd[k*8 +: 8] = 8'($urandom_range(0, 255));
      re = 5'($urandom_range(0, 31));
      run(rd, re, model(rd, re), 1'b0);
    end

    // Late start pulse and input changes during the run must not affect it.
    run(tbl[0].d, tbl[0].e, {tbl[0].q, tbl[0].r, tbl[0].c}, 1'b1);
    stray = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (busy !== 1'b0 || valid !== 1'b0) stray = 1'b1;
    end
    chk("no_queued_start", 64'(stray), 64'd0);

    // Reset inside DIVIDE aborts the run and clears outputs immediately.
    @(negedge clk);
    data  = tbl[1].d;
    en    = tbl[1].e;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_busy", 64'(busy), 64'd0);
    chk("midrun_reset_valid", 64'(valid), 64'd0);
    chk("midrun_reset_outputs", {temp_q, temp_r, nr}, 40'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    last_out = '0;
    run(tbl[6].d, tbl[6].e, {tbl[6].q, tbl[6].r, tbl[6].c}, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
